spi_mm_bridge: RTL and testbench
================================

// Module: spi_mm_bridge
// PURPOSE
//  SPI slave (mode 0) front end acting as memory-mapped bus master for the register slaves (product_test et al.).
//  Oversamples SCLK/CS_N/MOSI in clk_sys_i, decodes 32-bit frames [cmd8][addr8][data16] MSB-first,
//  issues single-cycle MM writes and captures MM read data for return on MISO in the same frame.
// PARAMETERS
//  MM_ADDR_WIDTH  8      MM address width (= addr byte width; fixed at 8 in this frame format)
//  MM_DATA_WIDTH  16     MM data width (= data phase length in bits)
//  CMD_WR         8'h02  command byte: write
//  CMD_RD         8'h03  command byte: read
// PORTS
//  clk_sys_i      in   1   system clock; all logic on posedge
//  rst_i          in   1   asynchronous, active-high reset
//  spi_sclk_i     in   1   SPI clock, async to clk_sys_i, idle low
//  spi_cs_n_i     in   1   SPI chip select, active low, async
//  spi_mosi_i     in   1   SPI data in, async
//  spi_miso_o     out  1   SPI data out
//  spi_miso_oe_o  out  1   MISO output enable (1 while CS active, synced)
//  mm_m_addr_o    out  8   MM address to slaves
//  mm_m_wdata_o   out  16  MM write data
//  mm_m_rdata_i   in   16  MM read data (combinational from slave addr decode)
//  mm_m_we_o      out  1   MM write strobe, one clk_sys_i cycle
//  frame_err_o    out  1   one-cycle pulse: frame aborted or bad command
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; bit counter, shift regs cleared. Reset mid-frame discards frame, no we.
//  Input sync: 2-flop sync on sclk/cs_n/mosi, plus 1 history flop for edge detect. Requires f_sclk <= f_clk/8.
//  rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d; both ignored while cs_n_s high.
//  FSM: IDLE -> CMD on cs_n_s falling; CMD(8 rises) -> ADDR(8) -> DATA(16) -> WAIT_CS.
//   any state: cs_n_s high before 32nd rise -> IDLE, frame_err_o pulse (if >=1 bit received), no we.
//   WAIT_CS: further SCLK edges ignored, MISO 0; cs_n_s high -> IDLE. No new frame until CS toggles.
//  6-bit bit counter increments on each rise in CMD/ADDR/DATA; MOSI shifted in MSB-first on rise.
//  After 8th rise: cmd latched. cmd not CMD_WR/CMD_RD -> frame_err_o pulse, go WAIT_CS.
//  After 16th rise: mm_m_addr_o <= addr byte (next clk). For read, cycle after addr update:
//   tx_shift <= mm_m_rdata_i (one-cycle settle for combinational slave read).
//  MISO: updated only on fall. CMD/ADDR phases: 0. Fall following 16th rise: drive tx_shift[15];
//   each subsequent fall in DATA shifts next bit. Write frames: MISO 0 throughout.
//  Write: on 32nd rise with cmd=CMD_WR -> mm_m_wdata_o <= data16 and mm_m_we_o=1 next cycle, exactly 1 cycle;
//   addr/wdata stable during we and held until next frame updates them.
//  Read frames never assert we. mm_m_addr_o held after frame ends.
//  spi_miso_oe_o = ~cs_n_s (registered); MISO forced 0 when oe low.
//  Latency: CS/SCLK edge to internal action = 3 clk_sys_i cycles (sync+edge).
// TESTING
//  Write frame 02,02,A5,5A -> one we pulse, addr=0x02, wdata=0xA55A; product_test test_reg reads back 0xA55A.
//  Read frame 03,00 + 16 dummy clocks, rdata=0x0105 -> MISO bits during DATA = 0x0105, we stays 0.
//  Abort: CS high after 20 bits of write frame -> no we, frame_err_o one pulse; next write frame completes normally.
//  Bad cmd 0x07 -> frame_err_o pulse after 8th bit, MISO 0, no we; 40 SCLKs total -> extras ignored.
//  rst_i asserted at bit 24 of write frame -> outputs 0 immediately, no we; post-release frame works.
//  Back-to-back write then read with min CS-high of 4 clk -> both frames decoded, read returns written value.

Source files
------------

// File: rtl/spi_mm_bridge.sv
// SPI mode-0 slave decoding [cmd8][addr8][data16] frames into single-cycle MM writes/reads; 3 clk_sys_i from SPI edge to action.
// No backpressure: MM slaves accept a write strobe every cycle and return read data combinationally.
module spi_mm_bridge #(
    parameter int         MM_ADDR_WIDTH = 8,
    parameter int         MM_DATA_WIDTH = 16,
    parameter logic [7:0] CMD_WR        = 8'h02,
    parameter logic [7:0] CMD_RD        = 8'h03
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_i,
    input  logic                     spi_sclk_i,
    input  logic                     spi_cs_n_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic                     spi_miso_oe_o,
    output logic [MM_ADDR_WIDTH-1:0] mm_m_addr_o,
    output logic [MM_DATA_WIDTH-1:0] mm_m_wdata_o,
    input  logic [MM_DATA_WIDTH-1:0] mm_m_rdata_i,
    output logic                     mm_m_we_o,
    output logic                     frame_err_o
);

    localparam int CMD_BITS   = 8;
    localparam int ADDR_END   = CMD_BITS + MM_ADDR_WIDTH;
    localparam int FRAME_BITS = ADDR_END + MM_DATA_WIDTH;

    localparam logic [5:0] CNT_CMD_LAST   = 6'(CMD_BITS - 1);
    localparam logic [5:0] CNT_ADDR_LAST  = 6'(ADDR_END - 1);
    localparam logic [5:0] CNT_FRAME_LAST = 6'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_WAIT_CS
    } state_t;

    state_t state, state_nxt;

    logic sclk_m, sclk_s, sclk_d;
    logic cs_n_m, cs_n_s, cs_n_d;
    logic mosi_m, mosi_s;

    logic                     rise, fall, cs_fall;
    logic [5:0]               bit_cnt;
    logic [MM_DATA_WIDTH-2:0] rx_shift;
    logic [MM_DATA_WIDTH-1:0] rx_word;
    logic [CMD_BITS-1:0]      cmd_q;
    logic [MM_DATA_WIDTH-1:0] tx_shift;
    logic                     rd_load;
    logic                     miso_q;
    logic                     is_rd, is_wr;

    logic in_frame, shift_en, cmd_done, addr_done, data_done, abort, bad_cmd;

    // Synchronisers plus one history stage for edge detection; CS idles high.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_d <= 1'b0;
            cs_n_m <= 1'b1;
            cs_n_s <= 1'b1;
            cs_n_d <= 1'b1;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sclk_m <= spi_sclk_i;
            sclk_s <= sclk_m;
            sclk_d <= sclk_s;
            cs_n_m <= spi_cs_n_i;
            cs_n_s <= cs_n_m;
            cs_n_d <= cs_n_s;
            mosi_m <= spi_mosi_i;
            mosi_s <= mosi_m;
        end
    end

    assign rise    = sclk_s & ~sclk_d & ~cs_n_s;
    assign fall    = ~sclk_s & sclk_d & ~cs_n_s;
    assign cs_fall = ~cs_n_s & cs_n_d;
    assign rx_word = {rx_shift, mosi_s};
    assign is_rd   = (cmd_q == CMD_RD);
    assign is_wr   = (cmd_q == CMD_WR);

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (cs_n_s)        state_nxt = ST_IDLE;
                else if (cmd_done) state_nxt = bad_cmd ? ST_WAIT_CS : ST_ADDR;
            end
            ST_ADDR: begin
                if (cs_n_s)         state_nxt = ST_IDLE;
                else if (addr_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (cs_n_s)         state_nxt = ST_IDLE;
                else if (data_done) state_nxt = ST_WAIT_CS;
            end
            ST_WAIT_CS: if (cs_n_s) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Frame-phase strobes; an abort only counts as an error once a bit has arrived.
    always_comb begin
        in_frame  = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
        shift_en  = 1'b0;
        cmd_done  = 1'b0;
        addr_done = 1'b0;
        data_done = 1'b0;
        abort     = 1'b0;
        bad_cmd   = 1'b0;
        if (in_frame && cs_n_s) begin
            abort = (bit_cnt != 6'd0);
        end else if (in_frame && rise) begin
            shift_en = 1'b1;
            case (state)
                ST_CMD: begin
                    if (bit_cnt == CNT_CMD_LAST) begin
                        cmd_done = 1'b1;
                        bad_cmd  = (rx_word[CMD_BITS-1:0] != CMD_WR) &&
                                   (rx_word[CMD_BITS-1:0] != CMD_RD);
                    end
                end
                ST_ADDR: addr_done = (bit_cnt == CNT_ADDR_LAST);
                ST_DATA: data_done = (bit_cnt == CNT_FRAME_LAST);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            cmd_q    <= '0;
        end else if (state == ST_IDLE) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (shift_en) begin
            bit_cnt  <= bit_cnt + 6'd1;
            rx_shift <= rx_word[MM_DATA_WIDTH-2:0];
            if (cmd_done) cmd_q <= rx_word[CMD_BITS-1:0];
        end
    end

    // Read data is captured one cycle after the address moves so the slave decode settles.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            mm_m_addr_o  <= '0;
            mm_m_wdata_o <= '0;
            mm_m_we_o    <= 1'b0;
            rd_load      <= 1'b0;
            tx_shift     <= '0;
            miso_q       <= 1'b0;
            frame_err_o  <= 1'b0;
            spi_miso_oe_o <= 1'b0;
        end else begin
            if (addr_done) mm_m_addr_o <= rx_word[MM_ADDR_WIDTH-1:0];
            rd_load <= addr_done && is_rd;
            if (data_done && is_wr) mm_m_wdata_o <= rx_word;
            mm_m_we_o <= data_done && is_wr;
            if (rd_load) begin
                tx_shift <= mm_m_rdata_i;
            end else if (fall && (state == ST_DATA) && is_rd) begin
                tx_shift <= {tx_shift[MM_DATA_WIDTH-2:0], 1'b0};
            end
            if ((state == ST_DATA) && is_rd) begin
                if (fall) miso_q <= tx_shift[MM_DATA_WIDTH-1];
            end else begin
                miso_q <= 1'b0;
            end
            frame_err_o   <= abort || bad_cmd;
            spi_miso_oe_o <= ~cs_n_s;
        end
    end

    assign spi_miso_o = miso_q & spi_miso_oe_o;

endmodule

// File: tb/tb_spi_mm_bridge.sv
// Bench for spi_mm_bridge: SPI master driving frames against a small register-file slave.
`timescale 1ns/1ps
module tb_spi_mm_bridge;

    localparam int HALF = 80;

    logic        clk_sys_i = 1'b0;
    logic        rst_i;
    logic        spi_sclk_i;
    logic        spi_cs_n_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic [7:0]  mm_m_addr_o;
    logic [15:0] mm_m_wdata_o;
    logic [15:0] mm_m_rdata_i;
    logic        mm_m_we_o;
    logic        frame_err_o;

    spi_mm_bridge dut (
        .clk_sys_i     (clk_sys_i),
        .rst_i         (rst_i),
        .spi_sclk_i    (spi_sclk_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .mm_m_addr_o   (mm_m_addr_o),
        .mm_m_wdata_o  (mm_m_wdata_o),
        .mm_m_rdata_i  (mm_m_rdata_i),
        .mm_m_we_o     (mm_m_we_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    // Register-file slave with combinational read.
    logic [15:0] regs [256];
    assign mm_m_rdata_i = regs[mm_m_addr_o];
    always @(posedge clk_sys_i) if (mm_m_we_o) regs[mm_m_addr_o] <= mm_m_wdata_o;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        int          exp_we;
        int          exp_err;
        logic [39:0] exp_rx;
    } vec_t;
    vec_t tbl[15];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt = 0;
    int   err_cycles = 0;
    logic we_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk_sys_i) begin
        if (!rst_i) begin
            if (mm_m_we_o) begin
                we_cnt++;
                chk("we_single_cycle", we_prev, 1'b0);
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_we: got addr %0h data %0h expected no write", mm_m_addr_o, mm_m_wdata_o);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("we_addr_data", {mm_m_addr_o, mm_m_wdata_o}, e);
                end
            end
            if (frame_err_o) err_cycles++;
            we_prev = mm_m_we_o;
        end
    end

    task automatic spi_xfer(input logic [31:0] fr, input int nbits, input bit keep_cs,
                            output logic [39:0] rx);
        logic [39:0] sh;
        sh = {fr, 8'h00};
        rx = '0;
        @(negedge clk_sys_i);
        spi_cs_n_i = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = sh[39];
            sh = sh << 1;
            #HALF;
            spi_sclk_i = 1'b1;
            rx = {rx[38:0], spi_miso_o};
            if (i == 0) chk("oe_in_frame", spi_miso_oe_o, 1'b1);
            #HALF;
            spi_sclk_i = 1'b0;
        end
        #HALF;
        if (!keep_cs) begin
            spi_cs_n_i = 1'b1;
            #HALF;
        end
    endtask

    task automatic run_frame(input string nm, input vec_t v);
        int          b_we, b_err;
        logic [39:0] rx;
        b_we  = we_cnt;
        b_err = err_cycles;
        if (v.exp_we != 0) wq.push_back({v.frame[23:16], v.frame[15:0]});
        spi_xfer(v.frame, v.nbits, 1'b0, rx);
        repeat (10) @(negedge clk_sys_i);
        chk({nm, "_we"}, 64'(we_cnt - b_we), 64'(v.exp_we));
        chk({nm, "_err"}, 64'(err_cycles - b_err), 64'(v.exp_err));
        chk({nm, "_miso"}, rx, v.exp_rx);
        chk({nm, "_idle"}, {spi_miso_oe_o, spi_miso_o}, 2'b00);
    endtask

    initial begin
        logic [39:0] rx;
        int          b_we;
        vec_t        v;

        for (int i = 0; i < 256; i++) regs[i] = {8'hC0, 8'(i)};
        regs[0] = 16'h0105;

        tbl[0]  = '{32'h0300_0000, 32, 0, 0, 40'h0105};
        tbl[1]  = '{32'h0202_A55A, 32, 1, 0, 40'h0};
        tbl[2]  = '{32'h0302_0000, 32, 0, 0, 40'hA55A};
        tbl[3]  = '{32'h0230_FFFF, 32, 1, 0, 40'h0};
        tbl[4]  = '{32'h0231_0000, 32, 1, 0, 40'h0};
        tbl[5]  = '{32'h0330_0000, 32, 0, 0, 40'hFFFF};
        tbl[6]  = '{32'h0331_FFFF, 32, 0, 0, 40'h0000};
        tbl[7]  = '{32'h03FF_0000, 32, 0, 0, 40'hC0FF};
        tbl[8]  = '{32'h0712_3456, 40, 0, 1, 40'h0};
        tbl[9]  = '{32'h0220_FFFF, 20, 0, 1, 40'h0};
        tbl[10] = '{32'h0220_0F0F, 32, 1, 0, 40'h0};
        tbl[11] = '{32'h0320_0000, 32, 0, 0, 40'h0F0F};
        tbl[12] = '{32'h0000_0000, 32, 0, 1, 40'h0};
        tbl[13] = '{32'h0200_0000, 1, 0, 1, 40'h0};
        tbl[14] = '{32'h0200_0000, 0, 0, 0, 40'h0};

        spi_sclk_i = 1'b0;
        spi_cs_n_i = 1'b1;
        spi_mosi_i = 1'b0;
        rst_i      = 1'b1;
        #2;
        chk("reset_outputs", {spi_miso_o, spi_miso_oe_o, mm_m_addr_o, mm_m_wdata_o, mm_m_we_o, frame_err_o}, 28'h0);
        repeat (4) @(negedge clk_sys_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_sys_i);

        for (int i = 0; i < 15; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of the data phase of a write frame.
        v = '{32'h0244_1111, 32, 1, 0, 40'h0};
        run_frame("pre_reset_wr", v);
        b_we = we_cnt;
        spi_xfer(32'h0244_2222, 24, 1'b1, rx);
        @(negedge clk_sys_i);
        rst_i = 1'b1;
        #1;
        chk("midframe_reset_outputs", {spi_miso_o, spi_miso_oe_o, mm_m_addr_o, mm_m_wdata_o, mm_m_we_o, frame_err_o}, 28'h0);
        repeat (3) @(negedge clk_sys_i);
        spi_cs_n_i = 1'b1;
        repeat (4) @(negedge clk_sys_i);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_sys_i);
        chk("midframe_reset_no_we", 64'(we_cnt - b_we), 64'd0);
        chk("midframe_reset_reg", regs[8'h44], 16'h1111);
        v = '{32'h0244_BEEF, 32, 1, 0, 40'h0};
        run_frame("post_reset_wr", v);
        v = '{32'h0344_0000, 32, 0, 0, 40'hBEEF};
        run_frame("post_reset_rd", v);

        // Back-to-back write then read with a 4-cycle CS-high gap.
        b_we = we_cnt;
        wq.push_back({8'h50, 16'hC3C3});
        spi_xfer(32'h0250_C3C3, 32, 1'b1, rx);
        spi_cs_n_i = 1'b1;
        repeat (3) @(negedge clk_sys_i);
        spi_xfer(32'h0350_0000, 32, 1'b0, rx);
        repeat (10) @(negedge clk_sys_i);
        chk("b2b_we", 64'(we_cnt - b_we), 64'd1);
        chk("b2b_read", rx, 40'hC3C3);

        chk("wq_drained", 64'(wq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
